// File: rtl/buffered_crossbar_stage.sv
// Buffered crossbar stage: each output owns a small FIFO fed by at most one selected input.
// Multicast pushes are all-or-nothing across every output that selects the same input.
module buffered_crossbar_stage #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 34,
  parameter int DEPTH     = 2,
  localparam int SEL_W    = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           preset,
  input  logic [NUM_PORTS-1:0]           sel_vld,
  input  logic [NUM_PORTS*SEL_W-1:0]     sel,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]    out_data,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS*CNT_W-1:0]     out_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] conn_s;   // [output][input]
  logic [NUM_PORTS-1:0]                full_s;
  logic [NUM_PORTS-1:0]                has_dem_s;
  logic [NUM_PORTS-1:0]                blocked_s;
  logic [NUM_PORTS-1:0]                accept_s;
  logic [NUM_PORTS-1:0]                push_s;
  logic [NUM_PORTS-1:0]                pop_s;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    wdata_s;

  logic [NUM_PORTS-1:0][CNT_W-1:0]     count_q, count_d;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]                   mem_q [NUM_PORTS][DEPTH];

  // Connection matrix; a select value outside 0..NUM_PORTS-1 never matches any input
  always_comb begin
    conn_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel_vld[o] && (sel[o*SEL_W +: SEL_W] == SEL_W'(i))) begin
          conn_s[o][i] = 1'b1;
        end else begin
          conn_s[o][i] = 1'b0;
        end
      end
    end
  end

  // Full flags come from registered counts only, so in_ready has no path from out_ready
  always_comb begin
    full_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      full_s[o] = (count_q[o] == CNT_W'(DEPTH));
    end
  end

  // Demand-set evaluation: an input is ready only if every output it feeds has room
  always_comb begin
    has_dem_s = '0;
    blocked_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (conn_s[o][i]) begin
          has_dem_s[i] = 1'b1;
          if (full_s[o]) begin
            blocked_s[i] = 1'b1;
          end else begin
            blocked_s[i] = blocked_s[i];
          end
        end else begin
          has_dem_s[i] = has_dem_s[i];
        end
      end
    end
  end

  assign in_ready  = has_dem_s & ~blocked_s & {NUM_PORTS{~preset}};
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign out_count = count_q;

  // Per-output push and write data from the single selected source
  always_comb begin
    push_s  = '0;
    wdata_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (conn_s[o][i] && accept_s[i]) begin
          push_s[o]  = 1'b1;
          wdata_s[o] = in_data[i*DATA_W +: DATA_W];
        end else begin
          push_s[o]  = push_s[o];
        end
      end
    end
  end

  // Next-state for counts and pointers
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (push_s[o]) begin
        wr_ptr_d[o] = wr_ptr_q[o] + PTR_W'(1);
      end else begin
        wr_ptr_d[o] = wr_ptr_q[o];
      end
      if (pop_s[o]) begin
        rd_ptr_d[o] = rd_ptr_q[o] + PTR_W'(1);
      end else begin
        rd_ptr_d[o] = rd_ptr_q[o];
      end
      case ({push_s[o], pop_s[o]})
        2'b10:   count_d[o] = count_q[o] + CNT_W'(1);
        2'b01:   count_d[o] = count_q[o] - CNT_W'(1);
        default: count_d[o] = count_q[o];
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (preset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; never reset, push is already suppressed while preset is high
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (push_s[o]) begin
        mem_q[o][wr_ptr_q[o]] <= wdata_s[o];
      end
    end
  end

  // Head presentation, forced to zero when the FIFO is empty
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid[o] = (count_q[o] != CNT_W'(0));
      if (out_valid[o]) begin
        out_data[o*DATA_W +: DATA_W] = mem_q[o][rd_ptr_q[o]];
      end else begin
        out_data[o*DATA_W +: DATA_W] = '0;
      end
    end
  end

endmodule

// File: tb/tb_buffered_crossbar_stage.sv
// Directed table-driven bench for buffered_crossbar_stage (5 ports, 34-bit flits, depth 2),
// followed by a wrap-around streaming sequence checked against an in-order counter.
module tb_buffered_crossbar_stage;

  localparam int NP = 5;
  localparam int DW = 34;
  localparam int SW = 3;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              preset;
  logic [NP-1:0]     sel_vld;
  logic [NP*SW-1:0]  sel;
  logic [NP-1:0]     in_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_ready;
  logic [NP-1:0]     out_valid;
  logic [NP*DW-1:0]  out_data;
  logic [NP-1:0]     out_ready;
  logic [NP*CW-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffered_crossbar_stage #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(2)) dut (
    .clk(clk), .preset(preset), .sel_vld(sel_vld), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_count(out_count)
  );

  typedef struct {
    logic          rst;
    logic [4:0]    sv;
    logic [14:0]   sl;
    logic [4:0]    iv;
    logic [33:0]   d;
    logic [4:0]    ordy;
    logic [4:0]    e_ird;   // in_ready before the edge
    logic [4:0]    e_ov;    // out_valid after the edge
    logic [9:0]    e_cnt;   // packed out_count after the edge
    int            chk_o;
    logic [33:0]   e_dat;   // out_data[chk_o] after the edge
  } vec_t;

  vec_t vt[$];

  function automatic logic [14:0] ps(int s0, int s1, int s2, int s3, int s4);
    ps = {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  function automatic vec_t mk(logic rst, logic [4:0] sv, logic [14:0] sl, logic [4:0] iv,
                              logic [33:0] d, logic [4:0] ordy, logic [4:0] e_ird,
                              logic [4:0] e_ov, logic [9:0] e_cnt, int chk_o, logic [33:0] e_dat);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sl = sl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ird = e_ird; v.e_ov = e_ov; v.e_cnt = e_cnt; v.chk_o = chk_o; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    bit do_push;
    bit do_pop;
    bit hold_chk;
    logic [33:0] held;

    preset    = 1'b1;
    sel_vld   = '0;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;

    //        rst  sv        sel            iv        data     ordy      ird       ov        cnt     o  dat
    vt.push_back(mk(1'b1, 5'b00000, ps(0,0,0,0,0), 5'b01000, 34'h1A5, 5'b00001, 5'b00000, 5'b00000, 10'h000, 0, 34'h0));
    // unicast input 3 -> output 0
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h1A5, 5'b00000, 5'b01000, 5'b00001, 10'h001, 0, 34'h1A5));
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h2B6, 5'b00000, 5'b01000, 5'b00001, 10'h002, 0, 34'h1A5));
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h3C7, 5'b00000, 5'b00000, 5'b00001, 10'h002, 0, 34'h1A5));
    // full with pop refuses the push; then push+pop at count 1
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h3C7, 5'b00001, 5'b00000, 5'b00001, 10'h001, 0, 34'h2B6));
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h4D8, 5'b00001, 5'b01000, 5'b00001, 10'h001, 0, 34'h4D8));
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b00000, 34'h0,   5'b00001, 5'b01000, 5'b00000, 10'h000, 0, 34'h0));
    // reconfiguration with two flits buffered
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h11,  5'b00000, 5'b01000, 5'b00001, 10'h001, 0, 34'h11));
    vt.push_back(mk(1'b0, 5'b00001, ps(3,0,0,0,0), 5'b01000, 34'h12,  5'b00000, 5'b01000, 5'b00001, 10'h002, 0, 34'h11));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h21,  5'b00000, 5'b00000, 5'b00001, 10'h002, 0, 34'h11));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h21,  5'b00001, 5'b00000, 5'b00001, 10'h001, 0, 34'h12));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h21,  5'b00001, 5'b00010, 5'b00001, 10'h001, 0, 34'h21));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h22,  5'b00000, 5'b00010, 5'b00001, 10'h002, 0, 34'h21));
    // reset while full, then resume
    vt.push_back(mk(1'b1, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h23,  5'b00001, 5'b00000, 5'b00000, 10'h000, 0, 34'h0));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00010, 34'h33,  5'b00000, 5'b00010, 5'b00001, 10'h001, 0, 34'h33));
    vt.push_back(mk(1'b0, 5'b00001, ps(1,0,0,0,0), 5'b00000, 34'h0,   5'b00001, 5'b00010, 5'b00000, 10'h000, 0, 34'h0));
    // multicast input 2 -> outputs 1 and 4 with output 4 full
    vt.push_back(mk(1'b0, 5'b10000, ps(0,0,0,0,2), 5'b00100, 34'h41,  5'b00000, 5'b00100, 5'b10000, 10'h100, 4, 34'h41));
    vt.push_back(mk(1'b0, 5'b10000, ps(0,0,0,0,2), 5'b00100, 34'h42,  5'b00000, 5'b00100, 5'b10000, 10'h200, 4, 34'h41));
    vt.push_back(mk(1'b0, 5'b10010, ps(0,2,0,0,2), 5'b00100, 34'h43,  5'b00000, 5'b00000, 5'b10000, 10'h200, 1, 34'h0));
    vt.push_back(mk(1'b0, 5'b10010, ps(0,2,0,0,2), 5'b00100, 34'h43,  5'b10000, 5'b00000, 5'b10000, 10'h100, 4, 34'h42));
    vt.push_back(mk(1'b0, 5'b10010, ps(0,2,0,0,2), 5'b00100, 34'h44,  5'b00000, 5'b00100, 5'b10010, 10'h204, 1, 34'h44));
    vt.push_back(mk(1'b0, 5'b10010, ps(0,2,0,0,2), 5'b00000, 34'h0,   5'b10010, 5'b00000, 5'b10000, 10'h100, 4, 34'h44));
    vt.push_back(mk(1'b0, 5'b10010, ps(0,2,0,0,2), 5'b00000, 34'h0,   5'b10000, 5'b00100, 5'b00000, 10'h000, 4, 34'h0));
    // out-of-range select on output 2
    vt.push_back(mk(1'b0, 5'b00101, ps(2,0,7,0,0), 5'b00100, 34'h55,  5'b00000, 5'b00100, 5'b00001, 10'h001, 2, 34'h0));
    vt.push_back(mk(1'b0, 5'b00101, ps(2,0,7,0,0), 5'b00000, 34'h0,   5'b00001, 5'b00100, 5'b00000, 10'h000, 2, 34'h0));

    @(posedge clk);
    #1;
    foreach (vt[k]) begin
      preset    = vt[k].rst;
      sel_vld   = vt[k].sv;
      sel       = vt[k].sl;
      in_valid  = vt[k].iv;
      in_data   = {NP{vt[k].d}};
      out_ready = vt[k].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vt[k].e_ird));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vt[k].e_ov));
      chk($sformatf("v%0d_out_count", k), 64'(out_count), 64'(vt[k].e_cnt));
      chk($sformatf("v%0d_out_data%0d", k, vt[k].chk_o),
          64'(out_data[vt[k].chk_o*DW +: DW]), 64'(vt[k].e_dat));
    end

    // Wrap-around stream 0x00..0x0F from input 3 to output 0 with random back-pressure
    preset    = 1'b0;
    sel_vld   = 5'b00001;
    sel       = ps(3,0,0,0,0);
    out_ready = '0;
    sent      = 0;
    rcv       = 0;
    cyc       = 0;
    hold_chk  = 1'b0;
    held      = '0;
    while (rcv < 16 && cyc < 400) begin
      if (hold_chk) begin
        chk("wrap_hold_stable", 64'(out_data[DW-1:0]), 64'(held));
      end
      in_valid  = (sent < 16) ? 5'b01000 : 5'b00000;
      in_data   = {NP{34'(sent)}};
      out_ready = {4'b0000, 1'($urandom_range(0, 1))};
      #1;
      do_push = in_valid[3] & in_ready[3];
      do_pop  = out_valid[0] & out_ready[0];
      if (do_pop) begin
        chk($sformatf("wrap_order%0d", rcv), 64'(out_data[DW-1:0]), 64'(rcv));
        rcv++;
      end
      hold_chk = out_valid[0] & ~out_ready[0];
      held     = out_data[DW-1:0];
      @(posedge clk);
      #1;
      if (do_push) sent++;
      cyc++;
    end
    chk("wrap_received", 64'(rcv), 64'd16);
    chk("wrap_final_count", 64'(out_count), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
